// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
//   Handshake and data bundle between the execute stage, the memory-access
//   stage and writeback.
//   master : upstream/downstream side (drives the execute result and
//            out_ready, observes the stage response)
//   slave  : the memory-access stage itself
//   Signals:
//     in_valid/in_ready          execute -> stage handshake
//     alu_result, write_data     byte address / store data
//     mem_read, mem_write        load / store control
//     branch, uncond_branch,zero CBZ / B control and zero flag
//     branch_target              execute branch target
//     out_valid/out_ready        stage -> writeback handshake
//     read_data                  load data (0 for non-loads)
//     alu_result_out,
//     branch_target_out          registered copies of the inputs
//     pc_src                     take-branch decision
//     err                        access fault
interface mem_access_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_result;
  logic [63:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        uncond_branch;
  logic        zero;
  logic [63:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] read_data;
  logic [63:0] alu_result_out;
  logic [63:0] branch_target_out;
  logic        pc_src;
  logic        err;

  modport master (
    output in_valid, alu_result, write_data, mem_read, mem_write,
           branch, uncond_branch, zero, branch_target, out_ready,
    input  in_ready, out_valid, read_data, alu_result_out,
           branch_target_out, pc_src, err
  );

  modport slave (
    input  in_valid, alu_result, write_data, mem_read, mem_write,
           branch, uncond_branch, zero, branch_target, out_ready,
    output in_ready, out_valid, read_data, alu_result_out,
           branch_target_out, pc_src, err
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access pipeline stage with a small doubleword data memory.
//   Captures one execute result per handshake, performs an optional load or
//   store after LATENCY access cycles, and presents a registered response to
//   writeback until it is accepted.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset (also clears the memory)
//     bus    mem_access_stage_if.slave (see interface header)
//   Parameters:
//     DEPTH    doublewords of data memory, power of two, >= 2
//     LATENCY  cycles spent in ACCESS for a load/store, 1..7
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | in_ready=1, waiting for an execute result
//   ACCESS | load/store in flight, cnt counts 0..LATENCY-1
//   RESP   | out_valid=1, outputs held until out_ready
module mem_access_stage #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input logic               clk,
  input logic               reset,
  mem_access_stage_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] idx_q;
  logic [63:0]   wdata_q;
  logic          is_store_q;

  logic          mem_op;
  logic          fault;
  logic          last_access;
  logic [AW-1:0] idx_in;
  logic          unused_addr_bits;

  assign mem_op = bus.mem_read | bus.mem_write;
  // Both controls set is treated exactly like a misaligned access.
  assign fault  = (bus.mem_read & bus.mem_write)
                | (mem_op & (bus.alu_result[2:0] != 3'b000));
  // Upper address bits are dropped so addresses wrap modulo DEPTH*8.
  assign idx_in = bus.alu_result[AW+2:3];
  assign last_access = (cnt == 3'(LATENCY - 1));
  assign unused_addr_bits = ^bus.alu_result[63:AW+3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      cnt                   <= 3'd0;
      idx_q                 <= '0;
      wdata_q               <= 64'd0;
      is_store_q            <= 1'b0;
      bus.in_ready          <= 1'b1;
      bus.out_valid         <= 1'b0;
      bus.read_data         <= 64'd0;
      bus.alu_result_out    <= 64'd0;
      bus.branch_target_out <= 64'd0;
      bus.pc_src            <= 1'b0;
      bus.err               <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            idx_q                 <= idx_in;
            wdata_q               <= bus.write_data;
            is_store_q            <= bus.mem_write;
            bus.alu_result_out    <= bus.alu_result;
            bus.branch_target_out <= bus.branch_target;
            bus.pc_src            <= bus.uncond_branch | (bus.branch & bus.zero);
            bus.err               <= fault;
            bus.read_data         <= 64'd0;
            bus.in_ready          <= 1'b0;
            if (mem_op && !fault) begin
              state <= ACCESS;
              cnt   <= 3'd0;
            end else begin
              state         <= RESP;
              bus.out_valid <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (last_access) begin
            if (is_store_q) mem[idx_q] <= wdata_q;
            else            bus.read_data <= mem[idx_q];
            state         <= RESP;
            bus.out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
//   Directed bench for mem_access_stage (DEPTH=32, LATENCY=2).
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;
  int   lat;

  mem_access_stage_if bus();

  mem_access_stage #(.DEPTH(32), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    bus.in_valid      = 1'b0;
    bus.alu_result    = 64'd0;
    bus.write_data    = 64'd0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.branch        = 1'b0;
    bus.uncond_branch = 1'b0;
    bus.zero          = 1'b0;
    bus.branch_target = 64'd0;
  endtask

  // Present one execute result, then count cycles until out_valid.
  task automatic issue(input string tag, input logic rd, input logic wr,
                       input logic br, input logic ub, input logic z,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] bt, output int cycles);
    @(negedge clk);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    bus.in_valid      = 1'b1;
    bus.mem_read      = rd;
    bus.mem_write     = wr;
    bus.branch        = br;
    bus.uncond_branch = ub;
    bus.zero          = z;
    bus.alu_result    = addr;
    bus.write_data    = wd;
    bus.branch_target = bt;
    @(posedge clk);
    #1;
    clear_inputs();
    cycles = 0;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (bus.out_valid) break;
    end
  endtask

  task automatic release_resp(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ret_in_ready"}, bus.in_ready, 1'b1);
    check({tag, "_ret_out_valid"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_read_data", bus.read_data, 64'd0);
    check("rst_alu_out", bus.alu_result_out, 64'd0);
    check("rst_bt_out", bus.branch_target_out, 64'd0);
    check("rst_pc_src", bus.pc_src, 1'b0);
    check("rst_err", bus.err, 1'b0);

    // store then load
    issue("stur80", 0, 1, 0, 0, 0, 64'd80, 64'h1234, 64'd0, lat);
    check("stur80_lat", 64'(lat), 64'd3);
    check("stur80_err", bus.err, 1'b0);
    check("stur80_rd", bus.read_data, 64'd0);
    check("stur80_alu", bus.alu_result_out, 64'd80);
    check("stur80_pc", bus.pc_src, 1'b0);
    release_resp("stur80");

    issue("ldur80", 1, 0, 0, 0, 0, 64'd80, 64'd0, 64'd0, lat);
    check("ldur80_lat", 64'(lat), 64'd3);
    check("ldur80_rd", bus.read_data, 64'h1234);
    check("ldur80_err", bus.err, 1'b0);
    release_resp("ldur80");

    // ALU-only op clears read_data left over from the load
    issue("alu", 0, 0, 0, 0, 0, 64'h55, 64'hFFFF, 64'h40, lat);
    check("alu_lat", 64'(lat), 64'd1);
    check("alu_rd", bus.read_data, 64'd0);
    check("alu_alu", bus.alu_result_out, 64'h55);
    check("alu_pc", bus.pc_src, 1'b0);
    // backpressure: hold out_ready low, new in_valid must be ignored
    for (int i = 0; i < 4; i++) begin
      bus.in_valid   = 1'b1;
      bus.alu_result = 64'hBAD;
      bus.branch     = 1'b1;
      bus.zero       = 1'b1;
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_in_ready", bus.in_ready, 1'b0);
      check("bp_alu", bus.alu_result_out, 64'h55);
      check("bp_pc", bus.pc_src, 1'b0);
    end
    clear_inputs();
    release_resp("bp");
    check("bp_alu_after", bus.alu_result_out, 64'h55);

    // branches
    issue("cbz", 0, 0, 1, 0, 1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, lat);
    check("cbz_lat", 64'(lat), 64'd1);
    check("cbz_pc", bus.pc_src, 1'b1);
    check("cbz_bt", bus.branch_target_out, 64'hFFFF_FFFF_FFFF_FFF0);
    check("cbz_rd", bus.read_data, 64'd0);
    release_resp("cbz");

    issue("cbz_nt", 0, 0, 1, 0, 0, 64'd0, 64'd0, 64'h100, lat);
    check("cbz_nt_pc", bus.pc_src, 1'b0);
    check("cbz_nt_bt", bus.branch_target_out, 64'h100);
    release_resp("cbz_nt");

    issue("b", 0, 0, 0, 1, 0, 64'd0, 64'd0, 64'h200, lat);
    check("b_pc", bus.pc_src, 1'b1);
    release_resp("b");

    // faults
    issue("ldur82", 1, 0, 0, 0, 0, 64'd82, 64'd0, 64'd0, lat);
    check("ldur82_lat", 64'(lat), 64'd1);
    check("ldur82_err", bus.err, 1'b1);
    check("ldur82_rd", bus.read_data, 64'd0);
    release_resp("ldur82");

    issue("stur8", 0, 1, 0, 0, 0, 64'd8, 64'hAAAA, 64'd0, lat);
    check("stur8_lat", 64'(lat), 64'd3);
    release_resp("stur8");

    issue("both8", 1, 1, 0, 0, 0, 64'd8, 64'hDEAD, 64'd0, lat);
    check("both8_lat", 64'(lat), 64'd1);
    check("both8_err", bus.err, 1'b1);
    check("both8_rd", bus.read_data, 64'd0);
    release_resp("both8");

    issue("stur12", 0, 1, 0, 0, 0, 64'd12, 64'hBEEF, 64'd0, lat);
    check("stur12_err", bus.err, 1'b1);
    check("stur12_lat", 64'(lat), 64'd1);
    release_resp("stur12");

    issue("ld8_a", 1, 0, 0, 0, 0, 64'd8, 64'd0, 64'd0, lat);
    check("ld8_a_rd", bus.read_data, 64'hAAAA);
    check("ld8_a_err", bus.err, 1'b0);
    release_resp("ld8_a");

    // address wrap: 264 maps to mem[1]
    issue("stur264", 0, 1, 0, 0, 0, 64'd264, 64'h7777, 64'd0, lat);
    check("stur264_err", bus.err, 1'b0);
    release_resp("stur264");

    issue("ld8_b", 1, 0, 0, 0, 0, 64'd8, 64'd0, 64'd0, lat);
    check("ld8_b_rd", bus.read_data, 64'h7777);
    release_resp("ld8_b");

    // reset during ACCESS of a store to 16
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.mem_write  = 1'b1;
    bus.alu_result = 64'd16;
    bus.write_data = 64'h9999;
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", bus.in_ready, 1'b1);
    check("abort_out_valid", bus.out_valid, 1'b0);

    issue("ld16", 1, 0, 0, 0, 0, 64'd16, 64'd0, 64'd0, lat);
    check("ld16_lat", 64'(lat), 64'd3);
    check("ld16_rd", bus.read_data, 64'd0);
    release_resp("ld16");

    issue("ld8_c", 1, 0, 0, 0, 0, 64'd8, 64'd0, 64'd0, lat);
    check("ld8_c_rd", bus.read_data, 64'd0);
    release_resp("ld8_c");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
